// File: rtl/sw_key_conditioner_pkg.sv
// Shared defaults and pio_word field layout for the switch/key conditioner.
package sw_key_pkg;
  localparam int N_SW_DEF     = 3;
  localparam int N_KEY_DEF    = 3;
  localparam int DEBOUNCE_DEF = 500000;
  localparam int PIO_W        = 16;
  localparam int SW_LSB       = 0;

  function automatic int pressed_lsb(input int n_sw);
    return n_sw;
  endfunction

  function automatic int event_lsb(input int n_sw, input int n_key);
    return n_sw + n_key;
  endfunction
endpackage

// File: rtl/sw_key_conditioner_if.sv
// Board-pin / PIO side signals of the conditioner; slave is the conditioner itself.
interface sw_key_conditioner_if #(
    parameter int N_SW  = 3,
    parameter int N_KEY = 3
);
    import sw_key_pkg::*;

    logic [N_SW-1:0]  SW;
    logic [N_KEY-1:0] KEY_N;
    logic [N_KEY-1:0] ack;
    logic [N_SW-1:0]  sw_stable;
    logic [N_KEY-1:0] key_pressed;
    logic [N_KEY-1:0] key_pulse;
    logic [N_KEY-1:0] key_event;
    logic [PIO_W-1:0] pio_word;

    modport master (
        output SW, KEY_N, ack,
        input  sw_stable, key_pressed, key_pulse, key_event, pio_word
    );

    modport slave (
        input  SW, KEY_N, ack,
        output sw_stable, key_pressed, key_pulse, key_event, pio_word
    );
endinterface

// File: rtl/sw_key_conditioner_debounce_bit.sv
// One raw pin: 2-FF synchroniser followed by a stable-run debouncer.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit RESET_LEVEL     = 1'b0,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic q
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             s;

    assign s = sync[1];

    // Any sample equal to q restarts the run; the counter tops out at CNT_MAX and never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {2{RESET_LEVEL}};
            cnt  <= '0;
            q    <= RESET_LEVEL;
        end else begin
            sync <= {sync[0], raw};
            if (s == q) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                q   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sw_key_conditioner.sv
// Debounced switches and keys, press pulses, sticky press events and PIO packing.
module sw_key_conditioner
    import sw_key_pkg::*;
#(
    parameter int N_SW            = N_SW_DEF,
    parameter int N_KEY           = N_KEY_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input logic                  CLOCK_50,
    input logic                  reset,
    sw_key_conditioner_if.slave  bus
);
    localparam int PRESSED_LSB = pressed_lsb(N_SW);
    localparam int EVENT_LSB   = event_lsb(N_SW, N_KEY);

    if (N_SW + 2 * N_KEY > PIO_W) begin : g_bad_width
        $error("sw_key_conditioner: fields do not fit in pio_word");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("sw_key_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [N_SW-1:0]  sw_q;
    logic [N_KEY-1:0] key_q;
    logic [N_KEY-1:0] pressed;
    logic [N_KEY-1:0] pressed_d;
    logic [N_KEY-1:0] pulse;
    logic [N_KEY-1:0] evt;
    logic [PIO_W-1:0] pio;

    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (1'b0),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk(CLOCK_50),
            .rst(reset),
            .raw(bus.SW[g]),
            .q  (sw_q[g])
        );
    end

    // Keys are debounced in raw (active-low) polarity and inverted afterwards; the
    // debouncer is polarity-symmetric, so this matches inverting right after the sync.
    for (genvar g = 0; g < N_KEY; g++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (1'b1),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk(CLOCK_50),
            .rst(reset),
            .raw(bus.KEY_N[g]),
            .q  (key_q[g])
        );
    end

    assign pressed = ~key_q;

    // A pulse coinciding with ack keeps the event set.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pressed_d <= '0;
            pulse     <= '0;
            evt       <= '0;
        end else begin
            pressed_d <= pressed;
            pulse     <= pressed & ~pressed_d;
            evt       <= pulse | (evt & ~bus.ack);
        end
    end

    always_comb begin
        pio                            = '0;
        pio[SW_LSB      +: N_SW]       = sw_q;
        pio[PRESSED_LSB +: N_KEY]      = pressed;
        pio[EVENT_LSB   +: N_KEY]      = evt;
    end

    assign bus.sw_stable   = sw_q;
    assign bus.key_pressed = pressed;
    assign bus.key_pulse   = pulse;
    assign bus.key_event   = evt;
    assign bus.pio_word    = pio;
endmodule

// File: tb/tb_sw_key_conditioner.sv
// Directed scenarios plus random pin activity against a window-based reference model.
module tb_sw_key_conditioner;
    localparam int D    = 8;
    localparam int NSW  = 3;
    localparam int NKEY = 3;
    localparam int NB   = NSW + NKEY;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sw_key_conditioner_if #(.N_SW(NSW), .N_KEY(NKEY)) bus ();

    sw_key_conditioner #(.N_SW(NSW), .N_KEY(NKEY), .DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    // Reference: synced sample = raw delayed by two edges; accepted level flips once the
    // last D synced samples all disagree with it.
    logic [NB-1:0]   m_s1, m_s2, m_q;
    logic [D-1:0]    m_hist [NB];
    logic [NKEY-1:0] m_prev, m_pulse, m_event;
    localparam logic [NB-1:0] RST_LVL = {{NKEY{1'b1}}, {NSW{1'b0}}};

    task automatic model_reset();
        m_s1 = RST_LVL; m_s2 = RST_LVL; m_q = RST_LVL;
        for (int i = 0; i < NB; i++) m_hist[i] = {D{RST_LVL[i]}};
        m_prev = '0; m_pulse = '0; m_event = '0;
    endtask

    task automatic model_step();
        logic [NB-1:0]   nq;
        logic [NKEY-1:0] pr;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NB; i++) begin
            m_hist[i] = {m_hist[i][D-2:0], m_s2[i]};
            nq[i] = (m_hist[i] == {D{~m_q[i]}}) ? m_s2[i] : m_q[i];
        end
        pr      = ~m_q[NB-1:NSW];
        m_event = m_pulse | (m_event & ~bus.ack);
        m_pulse = pr & ~m_prev;
        m_prev  = pr;
        m_s2    = m_s1;
        m_s1    = {bus.KEY_N, bus.SW};
        m_q     = nq;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NKEY-1:0] pr;
        pr = ~m_q[NB-1:NSW];
        chk("sw_stable",   16'(bus.sw_stable),   16'(m_q[NSW-1:0]));
        chk("key_pressed", 16'(bus.key_pressed), 16'(pr));
        chk("key_pulse",   16'(bus.key_pulse),   16'(m_pulse));
        chk("key_event",   16'(bus.key_event),   16'(m_event));
        chk("pio_word",    bus.pio_word,         {7'd0, m_event, pr, m_q[NSW-1:0]});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int pulses;
    int lat;
    bit found;

    initial begin
        bus.SW = '0; bus.KEY_N = '1; bus.ack = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        chk("reset_pio", bus.pio_word, 16'h0000);
        rst = 1'b0;

        // clean press on key 1, then release without ack
        bus.KEY_N[1] = 1'b0;
        run(12);
        chk("press_pio", bus.pio_word, 16'h0090);
        run(8);
        bus.KEY_N[1] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.key_pulse[1]) pulses++;
        end
        chk("release_pressed", 16'(bus.key_pressed[1]), 16'd0);
        chk("release_pulses", 16'(pulses), 16'd0);
        chk("release_event", 16'(bus.key_event[1]), 16'd1);
        bus.ack[1] = 1'b1; cycle(); bus.ack[1] = 1'b0; cycle();

        // bounce on key 0
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            bus.KEY_N[0] = ~bus.KEY_N[0];
            for (int k = 0; k < 3; k++) begin
                cycle();
                if (bus.key_pulse[0]) pulses++;
            end
        end
        chk("bounce_pulses", 16'(pulses), 16'd0);
        bus.KEY_N[0] = 1'b0;
        lat = 0;
        pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            cycle();
            if (bus.key_pulse[0]) begin
                pulses++;
                lat = i;
            end
        end
        chk("bounce_final_pulses", 16'(pulses), 16'd1);
        chk("bounce_pulse_lat", 16'(lat), 16'd11);
        bus.KEY_N[0] = 1'b1;
        run(12);
        bus.ack[0] = 1'b1; cycle(); bus.ack[0] = 1'b0; cycle();

        // ack in the same cycle as the pulse on key 2
        bus.KEY_N[2] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_pulse[2]) found = 1'b1;
        end
        chk("race_pulse_seen", 16'(found), 16'd1);
        bus.ack[2] = 1'b1;
        cycle();
        chk("race_event_kept", 16'(bus.key_event[2]), 16'd1);
        cycle();
        chk("race_event_clr", 16'(bus.key_event[2]), 16'd0);
        bus.ack[2] = 1'b0;
        bus.KEY_N[2] = 1'b1;
        run(12);

        // switches, then a short glitch
        bus.SW = 3'b101;
        run(10);
        chk("sw_value", 16'(bus.sw_stable), 16'h0005);
        chk("sw_pio", bus.pio_word, 16'h0005);
        bus.SW[1] = 1'b1;
        run(5);
        bus.SW[1] = 1'b0;
        run(12);
        chk("sw_glitch", 16'(bus.sw_stable), 16'h0005);

        // reset mid-debounce with key 0 held
        bus.KEY_N[0] = 1'b0;
        run(7);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_pio_async", bus.pio_word, 16'h0000);
        run(3);
        rst = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cycle();
            if (bus.key_pressed[0]) lat = i;
        end
        chk("rst_press_lat", 16'(lat), 16'd10);
        cycle();
        chk("rst_press_pulse", 16'(bus.key_pulse[0]), 16'd1);
        run(2);
        bus.KEY_N[0] = 1'b1;
        bus.ack = '1;
        cycle();
        bus.ack = '0;
        run(12);

        // random pin activity, acks and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                int b = $urandom_range(0, NB - 1);
                if (b < NSW) bus.SW[b] = ~bus.SW[b];
                else bus.KEY_N[b - NSW] = ~bus.KEY_N[b - NSW];
            end
            for (int k = 0; k < NKEY; k++) bus.ack[k] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
